fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-side control stage of the dual-clock FIFO. It sits directly downstream of the write-domain Gray pointer counter and consumes its Gray-coded write pointer. The write pointer is synchronized into the read clock domain and converted to binary. The block then maintains the read pointer (binary RAM address plus Gray copy returned to the write domain) and derives empty, almost-empty and fill level.

## Interface
Parameters:
- ADDR_W, 4, FIFO RAM address width; pointers are ADDR_W+1 bits (one wrap bit)
- ALMOST_EMPTY, 2, almost_empty asserted when level <= ALMOST_EMPTY

Ports:
- clk  in  1  read-domain clock
- rst_n  in  1  reset, synchronous, active-low
- w_gray_ptr  in  ADDR_W+1  write pointer, Gray-coded, asynchronous to clk
- r_en  in  1  read request
- r_ack  out  1  read accepted this cycle
- r_addr  out  ADDR_W  RAM read address
- r_gray_ptr  out  ADDR_W+1  read pointer, Gray-coded, registered, for write-domain sync
- empty  out  1  no data available
- almost_empty  out  1  level <= ALMOST_EMPTY
- level  out  ADDR_W+1  words available, 0..2^ADDR_W
- err  out  1  sticky error flag (FIFO_RD_ERR_EN only, else tied 0)

## Operation
- Synchronizer: two flops, sync1 <= w_gray_ptr and sync2 <= sync1. No logic between the two flops.
- Gray-to-binary conversion: w_bin[i] = XOR of sync2[ADDR_W:i]. The result is registered into w_bin_q.
- Read pointer: r_bin is a binary register of ADDR_W+1 bits.
  - On r_ack, r_bin <= r_bin + 1, wrapping modulo 2^(ADDR_W+1).
  - On r_ack, r_gray_ptr <= (r_bin+1) ^ ((r_bin+1) >> 1).
- r_addr = r_bin[ADDR_W-1:0].
- level = (w_bin_q - r_bin) mod 2^(ADDR_W+1). This is combinational from registers.
- empty = (level == 0).
- almost_empty = (level <= ALMOST_EMPTY).
- r_ack = r_en & ~empty. A read while empty is ignored and the pointer does not move.
- State is implicit: the pointer registers only. No FSM beyond the pointer update.

## Timing
- Reset (rst_n low at a clk edge) clears sync1, sync2, w_bin_q, r_bin, r_gray_ptr and err to 0. Resulting outputs:
  - empty = 1, almost_empty = 1
  - level = 0, r_addr = 0, r_gray_ptr = 0
  - r_ack = 0, err = 0
- Reset mid-operation discards synchronized and local pointers on the same edge. The write side must be reset concurrently.
- Write latency: a w_gray_ptr change that is stable before edge N is visible in level/empty after edge N+2 (sync1 at N, sync2 at N+1, w_bin_q at N+2).
- r_ack is combinational in the same cycle as r_en. r_addr, level and empty reflect the read after the next edge.
- Simultaneous read and write-pointer advance: level equals the last w_bin_q minus the updated r_bin. No word is lost or duplicated.
- Wrap-around: r_bin goes 2^(ADDR_W+1)-1 -> 0. level stays correct through the modular subtraction.
- Full (level = 2^ADDR_W) is a legal value. empty = 0 when full.

## Configuration
- FIFO_RD_ERR_EN defined:
  - err sets on underflow attempt (r_en & empty).
  - err also sets on an impossible level (level > 2^ADDR_W).
  - err is sticky until reset.
- FIFO_RD_ERR_EN undefined: err is tied to 0 and no detection logic is built.

## Test plan
- Reset: hold rst_n=0 for 2 edges -> empty=1, almost_empty=1, level=0, r_addr=0, r_gray_ptr=0, err=0.
- Single write: ADDR_W=4, w_gray_ptr 0 -> 5'b00001 before edge N -> empty falls after edge N+2, level=1. Then r_en=1 for one cycle -> r_ack=1, next cycle empty=1, r_gray_ptr=5'b00001.
- Underflow: r_en=1 while empty -> r_ack=0, r_addr unchanged. err=1 with FIFO_RD_ERR_EN, err=0 without.
- Full and drain: w_gray_ptr = Gray(16) = 5'b11000 -> level=16, almost_empty=0. Then 16 reads -> r_addr sequence 0..15, final level=0.
- Wrap-around: preload pointers to 30, write 4 (w_gray_ptr to Gray(2)=5'b00011) -> level=4. Drain 4 -> r_bin goes 30, 31, 0, 1, 2 with correct r_gray_ptr at each step.
- Concurrent plus reset: interleave reads with write-pointer steps every cycle and check level against the model. Assert rst_n=0 mid-burst -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side handshake bundle of the dual-clock FIFO: write pointer in, read pointer/flags out.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W:0]   w_gray_ptr;
  logic              r_en;
  logic              r_ack;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_gray_ptr;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              err;

  modport master (
    output w_gray_ptr, r_en,
    input  r_ack, r_addr, r_gray_ptr, empty, almost_empty, level, err
  );

  modport slave (
    input  w_gray_ptr, r_en,
    output r_ack, r_addr, r_gray_ptr, empty, almost_empty, level, err
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer control of the dual-clock FIFO: syncs the Gray write pointer, tracks the read pointer.
// Optional macro FIFO_RD_ERR_EN builds the sticky underflow / impossible-level error flag.
module fifo_rd_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_rd_ctrl_if.slave  bus
);
  localparam logic [ADDR_W:0] AE_LEVEL = (ADDR_W+1)'(ALMOST_EMPTY);

  logic [ADDR_W:0] sync1_reg;
  logic [ADDR_W:0] sync2_reg;
  logic [ADDR_W:0] w_bin_next;
  logic [ADDR_W:0] w_bin_reg;
  logic [ADDR_W:0] r_bin_reg;
  logic [ADDR_W:0] r_bin_next;
  logic [ADDR_W:0] r_gray_reg;
  logic [ADDR_W:0] level_next;
  logic            empty_next;
  logic            r_ack_next;

  // Two plain flops back to back; nothing may sit between them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.w_gray_ptr;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi <= ADDR_W; gi++) begin : g_gray2bin
      assign w_bin_next[gi] = ^sync2_reg[ADDR_W:gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_bin_reg <= '0;
    end else begin
      w_bin_reg <= w_bin_next;
    end
  end

  // Modular subtraction keeps level correct across pointer wrap.
  assign level_next = w_bin_reg - r_bin_reg;
  assign empty_next = (level_next == '0);
  assign r_ack_next = bus.r_en & ~empty_next;
  assign r_bin_next = r_bin_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin_reg  <= '0;
      r_gray_reg <= '0;
    end else if (r_ack_next) begin
      r_bin_reg  <= r_bin_next;
      r_gray_reg <= r_bin_next ^ (r_bin_next >> 1);
    end
  end

  assign bus.r_ack        = r_ack_next;
  assign bus.r_addr       = r_bin_reg[ADDR_W-1:0];
  assign bus.r_gray_ptr   = r_gray_reg;
  assign bus.level        = level_next;
  assign bus.empty        = empty_next;
  assign bus.almost_empty = (level_next <= AE_LEVEL);

`ifdef FIFO_RD_ERR_EN
  logic err_reg;
  logic level_bad;

  // Anything above 2^ADDR_W means the pointers have diverged.
  assign level_bad = level_next[ADDR_W] & (|level_next[ADDR_W-1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if ((bus.r_en & empty_next) | level_bad) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif
endmodule
